wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_ctrl.sv | 110 +++++++++++
 tb/tb_wb_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared core constants and the writeback entry format used by wb_ctrl and its LSU buffer.
package wb_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // One buffered LSU result: destination register and load data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // One-hot scoreboard bit for a register; x0 never maps to a bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot = '0;
        if (r != '0) begin
            reg_onehot[r] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering LSU results until the write port is free.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
    import wb_ctrl_pkg::*;
#(
    parameter int DATA_W = REG_ADDR_W + XLEN,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        din_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Pointer and occupancy next-state; push+pop together leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates the ALU result and buffered LSU results onto a
// single registered register-file write port, and keeps the load scoreboard.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t             push_ent;
    wb_entry_t             head;
    logic [CNT_W-1:0]      count;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  alu_sel;
    logic                  issue_accept;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // Readiness looks only at the registered count; a pop this cycle frees space next cycle.
    assign lsu_ready    = !rst && (count < CNT_W'(FIFO_DEPTH));
    assign push_ent     = '{rd: lsu_rd, data: lsu_data};
    // x0 loads are acknowledged but never stored.
    assign fifo_push    = lsu_valid && lsu_ready && (lsu_rd != '0);
    // An x0 ALU result does not claim the port, so the buffer may drain that cycle.
    assign alu_sel      = alu_valid && (alu_rd != '0);
    assign fifo_pop     = !alu_sel && (count != '0);

    assign stall        = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
    assign issue_accept = issue_valid && !stall && (issue_rd != '0);

    wb_fifo #(
        .DATA_W ($bits(wb_entry_t)),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_ent),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .count_o (count)
    );

    // Write-port selection and scoreboard update; a new issue overrides a same-cycle clear.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        if (alu_sel) begin
            wr_en_d   = 1'b1;
            rd_d      = alu_rd;
            rd_data_d = alu_data;
        end else if (fifo_pop) begin
            wr_en_d   = 1'b1;
            rd_d      = head.rd;
            rd_data_d = head.data;
            busy_d    = busy_d & ~reg_onehot(head.rd);
        end
        if (issue_accept) begin
            busy_d = busy_d | reg_onehot(issue_rd);
        end
        busy_d[0] = 1'b0;
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign rd        = rd_q;
    assign rd_data   = rd_data_q;
    assign busy_mask = busy_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed vector table, hand-written multi-cycle
// sequences (full buffer, async reset) and a randomized run against a queue model.
module tb_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        stall;
    logic [31:0] busy_mask;
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .wr_en       (wr_en),
        .rd          (rd),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [4:0]  ird, irs1, irs2;
        logic        e_stall, e_ready, e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data, e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                          input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
                          input logic [4:0] irs2);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adat;
        lsu_valid   = lv;
        lsu_rd      = lrd;
        lsu_data    = ldat;
        issue_valid = iv;
        issue_rd    = ird;
        issue_rs1   = irs1;
        issue_rs2   = irs2;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
                       input logic [4:0] irs2, input logic es, input logic er,
                       input logic ew, input logic [4:0] erd, input logic [31:0] edat,
                       input logic [31:0] ebusy);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.iv = iv; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
        v.e_stall = es; v.e_ready = er; v.e_wr = ew;
        v.e_rd = erd; v.e_data = edat; v.e_busy = ebusy;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        ent_t        mq[$];
        ent_t        e;
        logic [31:0] mbusy;
        logic        m_wr;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        logic        m_ready, m_stall;
        ent_t        seen[$];
        logic        accepted;

        idle();
        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd", 32'(rd), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_lsu_ready", 32'(lsu_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_lsu_ready", 32'(lsu_ready), 1);

        // ---------------- directed vector table ----------------
        //   alu         lsu                 issue rd rs1 rs2   stall rdy  wr rd  data         busy
        add(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 5, 32'h12345678, 32'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 5, 32'h12345678, 32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 7, 1, 2,              0, 1, 0, 5, 32'h12345678, 32'h80);
        add(0, 0, 0, 0, 0, 0, 1, 8, 7, 0,              1, 1, 0, 5, 32'h12345678, 32'h80);
        add(0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0,   0, 1, 0, 5, 32'h12345678, 32'h80);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 1, 7, 32'hA5A5A5A5, 32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 8, 7, 0,              0, 1, 0, 7, 32'hA5A5A5A5, 32'h100);
        add(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0,         0, 1, 0, 7, 32'hA5A5A5A5, 32'h100);
        add(1, 4, 32'h40, 0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 4, 32'h40, 32'h100);
        add(1, 4, 32'h41, 0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 4, 32'h41, 32'h100);
        add(1, 4, 32'h42, 0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 4, 32'h42, 32'h100);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 1, 3, 32'h33, 32'h100);
        add(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 0, 0, 0, 1, 0, 3, 32'h33, 32'h100);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 0, 3, 32'h33, 32'h100);
        add(0, 0, 0, 1, 8, 32'h88, 0, 0, 0, 0,         0, 1, 0, 3, 32'h33, 32'h100);
        add(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 8, 32'h88, 32'h0);
        add(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0,         0, 1, 0, 8, 32'h88, 32'h200);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 1, 1, 9, 32'h99, 32'h0);
        add(0, 0, 0, 1, 10, 32'hAA, 0, 0, 0, 0,        0, 1, 0, 9, 32'h99, 32'h0);
        add(0, 0, 0, 0, 0, 0, 1, 10, 0, 0,             0, 1, 1, 10, 32'hAA, 32'h400);
        add(0, 0, 0, 0, 0, 0, 1, 11, 1, 10,            1, 1, 0, 10, 32'hAA, 32'h400);
        add(0, 0, 0, 0, 0, 0, 1, 10, 0, 0,             1, 1, 0, 10, 32'hAA, 32'h400);

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat,
                   tbl[i].iv, tbl[i].ird, tbl[i].irs1, tbl[i].irs2);
            #1;
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d_ready", i), 32'(lsu_ready), 32'(tbl[i].e_ready));
            tick();
            check($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].e_wr));
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(tbl[i].e_rd));
            check($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].e_data);
            check($sformatf("vec%0d_busy", i), busy_mask, tbl[i].e_busy);
        end

        // ---------------- full buffer: third load waits, arrival order kept ----------------
        do_reset();
        set_in(1, 4, 32'h400, 1, 1, 32'h101, 0, 0, 0, 0);
        #1 check("full_ready0", 32'(lsu_ready), 1);
        tick();
        set_in(1, 4, 32'h401, 1, 2, 32'h102, 0, 0, 0, 0);
        #1 check("full_ready1", 32'(lsu_ready), 1);
        tick();
        set_in(1, 4, 32'h402, 1, 5, 32'h105, 0, 0, 0, 0);
        #1 check("full_ready_low", 32'(lsu_ready), 0);
        tick();
        check("full_alu_wr_rd", 32'(rd), 4);
        alu_valid = 1'b0;
        seen.delete();
        for (int c = 0; c < 12 && seen.size() < 3; c++) begin
            #1;
            accepted = lsu_valid && lsu_ready;
            tick();
            if (wr_en) begin
                e.rd = rd;
                e.data = rd_data;
                seen.push_back(e);
            end
            if (accepted) lsu_valid = 1'b0;
        end
        check("full_write_count", 32'(seen.size()), 3);
        if (seen.size() == 3) begin
            check("full_order0_rd", 32'(seen[0].rd), 1);
            check("full_order0_data", seen[0].data, 32'h101);
            check("full_order1_rd", 32'(seen[1].rd), 2);
            check("full_order1_data", seen[1].data, 32'h102);
            check("full_order2_rd", 32'(seen[2].rd), 5);
            check("full_order2_data", seen[2].data, 32'h105);
        end

        // ---------------- asynchronous reset with buffered entries ----------------
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        set_in(1, 4, 32'h44, 1, 2, 32'h222, 0, 0, 0, 0);
        tick();
        set_in(1, 4, 32'h45, 1, 3, 32'h333, 0, 0, 0, 0);
        tick();
        check("arst_pre_busy", busy_mask, 32'h0C);
        check("arst_pre_ready", 32'(lsu_ready), 0);
        check("arst_pre_wr_en", 32'(wr_en), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_wr_en", 32'(wr_en), 0);
        check("arst_rd", 32'(rd), 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_busy", busy_mask, 0);
        check("arst_ready", 32'(lsu_ready), 0);
        idle();
        tick();
        rst = 1'b0;
        #1 check("arst_release_ready", 32'(lsu_ready), 1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("arst_no_stale_wr%0d", c), 32'(wr_en), 0);
        end
        check("arst_release_busy", busy_mask, 0);

        // ---------------- randomized run against queue model ----------------
        do_reset();
        mq.delete();
        mbusy  = '0;
        m_wr   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        for (int c = 0; c < 500; c++) begin
            set_in(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            m_ready = (mq.size() < DEPTH);
            m_stall = issue_valid && (mbusy[issue_rs1] || mbusy[issue_rs2] || mbusy[issue_rd]);
            #1;
            check($sformatf("rnd%0d_stall", c), 32'(stall), 32'(m_stall));
            check($sformatf("rnd%0d_ready", c), 32'(lsu_ready), 32'(m_ready));
            // model the edge: choose writer from pre-edge buffer, then accept new load
            m_wr = 1'b0;
            if (alu_valid && alu_rd != 0) begin
                m_wr = 1'b1;
                m_rd = alu_rd;
                m_data = alu_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wr = 1'b1;
                m_rd = e.rd;
                m_data = e.data;
                mbusy[e.rd] = 1'b0;
            end
            if (lsu_valid && m_ready && lsu_rd != 0) begin
                e.rd = lsu_rd;
                e.data = lsu_data;
                mq.push_back(e);
            end
            if (issue_valid && !m_stall && issue_rd != 0) mbusy[issue_rd] = 1'b1;
            mbusy[0] = 1'b0;
            tick();
            check($sformatf("rnd%0d_wr_en", c), 32'(wr_en), 32'(m_wr));
            check($sformatf("rnd%0d_rd", c), 32'(rd), 32'(m_rd));
            check($sformatf("rnd%0d_rd_data", c), rd_data, m_data);
            check($sformatf("rnd%0d_busy", c), busy_mask, mbusy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
